// File: rtl/axi_llc_tag_flush_seq.sv
`default_nettype none
// ============================================================================
//  Module   : axi_llc_tag_flush_seq
//  Purpose  : Initiator-side flush sequencer for the LLC tag storage. Accepts
//             a way-mask flush command, walks every index of each selected,
//             non-SPM way in ascending way order, issues one Flush request per
//             line to the tag store and forwards dirty lines as eviction
//             descriptors to the write-back path.
//  Ports    : clk_i/rst_i            clock, asynchronous active-high reset
//             spm_lock_i/flush_way_i  SPM-locked ways / ways to flush
//             flush_valid_i/_ready_o  flush command handshake
//             req_o/req_valid_o/req_ready_i   tag-store request channel
//             res_i/res_valid_i/res_ready_o   tag-store response channel
//             evict_*_o/evict_valid_o/evict_ready_i  eviction descriptor
//             flushed_o               ways whose flush has completed
//             busy_o/done_o           status, done is a one-cycle pulse
//  Request layout  (MSB..LSB): mode[1:0], indicator, index, tag, dirty
//  Response layout (MSB..LSB): indicator, hit, evict, evict_tag
//  Revision : 1.0 - initial release
// ============================================================================
module axi_llc_tag_flush_seq #(
    parameter int unsigned SET_ASSOCIATIVITY = 4,
    parameter int unsigned NUM_LINES         = 4,
    parameter int unsigned INDEX_LENGTH      = 2,
    parameter int unsigned TAG_LENGTH        = 8,
    parameter logic [1:0]  FLUSH_MODE        = 2'd2
) (
    input  logic                                                      clk_i,
    input  logic                                                      rst_i,
    input  logic [SET_ASSOCIATIVITY-1:0]                              spm_lock_i,
    input  logic [SET_ASSOCIATIVITY-1:0]                              flush_way_i,
    input  logic                                                      flush_valid_i,
    output logic                                                      flush_ready_o,
    output logic [2+SET_ASSOCIATIVITY+INDEX_LENGTH+TAG_LENGTH:0]      req_o,
    output logic                                                      req_valid_o,
    input  logic                                                      req_ready_i,
    input  logic [SET_ASSOCIATIVITY+TAG_LENGTH+1:0]                   res_i,
    input  logic                                                      res_valid_i,
    output logic                                                      res_ready_o,
    output logic [TAG_LENGTH-1:0]                                     evict_tag_o,
    output logic [INDEX_LENGTH-1:0]                                   evict_index_o,
    output logic [SET_ASSOCIATIVITY-1:0]                              evict_way_o,
    output logic                                                      evict_valid_o,
    input  logic                                                      evict_ready_i,
    output logic [SET_ASSOCIATIVITY-1:0]                              flushed_o,
    output logic                                                      busy_o,
    output logic                                                      done_o
);

    typedef struct packed {
        logic [1:0]                   mode;
        logic [SET_ASSOCIATIVITY-1:0] indicator;
        logic [INDEX_LENGTH-1:0]      index;
        logic [TAG_LENGTH-1:0]        tag;
        logic                         dirty;
    } store_req_t;

    typedef struct packed {
        logic [SET_ASSOCIATIVITY-1:0] indicator;
        logic                         hit;
        logic                         evict;
        logic [TAG_LENGTH-1:0]        evict_tag;
    } store_res_t;

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_SEL   = 3'd1;
    localparam logic [2:0] c_REQ   = 3'd2;
    localparam logic [2:0] c_RESP  = 3'd3;
    localparam logic [2:0] c_EVICT = 3'd4;
    localparam logic [2:0] c_DONE  = 3'd5;

    localparam logic [INDEX_LENGTH-1:0]      c_LAST_IDX = INDEX_LENGTH'(NUM_LINES - 1);
    localparam logic [INDEX_LENGTH-1:0]      c_IDX_ONE  = INDEX_LENGTH'(1);
    localparam logic [SET_ASSOCIATIVITY-1:0] c_WAY_ONE  = SET_ASSOCIATIVITY'(1);

    logic [2:0]                   r_state;
    logic [SET_ASSOCIATIVITY-1:0] r_remain;
    logic [SET_ASSOCIATIVITY-1:0] r_way;
    logic [SET_ASSOCIATIVITY-1:0] r_flushed;
    logic [INDEX_LENGTH-1:0]      r_idx;
    logic [TAG_LENGTH-1:0]        r_evict_tag;
    logic [INDEX_LENGTH-1:0]      r_evict_index;
    logic [SET_ASSOCIATIVITY-1:0] r_evict_way;

    store_req_t                   w_req;
    store_res_t                   w_res;
    logic [SET_ASSOCIATIVITY-1:0] w_lowest;
    logic                         w_last;
    logic                         w_advance;
    logic                         w_unused;

    assign w_res    = res_i;
    // Isolate the lowest set bit: x & -x.
    assign w_lowest = r_remain & (~r_remain + c_WAY_ONE);
    assign w_last   = (r_idx == c_LAST_IDX);
    // A line is finished either on a clean response or once its
    // eviction descriptor has been taken by the write-back path.
    assign w_advance = ((r_state == c_RESP) && res_valid_i && !w_res.evict) ||
                       ((r_state == c_EVICT) && evict_ready_i);
    // Hit and echoed indicator carry no information for a flush walk.
    assign w_unused = ^{w_res.hit, w_res.indicator};

    // Request fields come from registers only, so they stay stable while
    // waiting for req_ready_i; the bus reads zero outside REQ.
    always_comb begin
        w_req = '0;
        if (r_state == c_REQ) begin
            w_req.mode      = FLUSH_MODE;
            w_req.indicator = r_way;
            w_req.index     = r_idx;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= c_IDLE;
            r_remain      <= '0;
            r_way         <= '0;
            r_flushed     <= '0;
            r_idx         <= '0;
            r_evict_tag   <= '0;
            r_evict_index <= '0;
            r_evict_way   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (flush_valid_i) begin
                        // SPM mask is sampled only here; later lock changes
                        // do not affect a flush already in progress.
                        r_remain  <= flush_way_i & ~spm_lock_i;
                        r_flushed <= r_flushed & ~flush_way_i;
                        r_state   <= c_SEL;
                    end
                end
                c_SEL: begin
                    if (r_remain == '0) begin
                        r_state <= c_DONE;
                    end else begin
                        r_way   <= w_lowest;
                        r_idx   <= '0;
                        r_state <= c_REQ;
                    end
                end
                c_REQ: begin
                    if (req_ready_i) begin
                        r_state <= c_RESP;
                    end
                end
                c_RESP: begin
                    if (res_valid_i && w_res.evict) begin
                        r_evict_tag   <= w_res.evict_tag;
                        r_evict_index <= r_idx;
                        r_evict_way   <= r_way;
                        r_state       <= c_EVICT;
                    end
                end
                c_EVICT: begin
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase

            if (w_advance) begin
                if (w_last) begin
                    r_flushed <= r_flushed | r_way;
                    r_remain  <= r_remain & ~r_way;
                    r_state   <= c_SEL;
                end else begin
                    r_idx   <= r_idx + c_IDX_ONE;
                    r_state <= c_REQ;
                end
            end
        end
    end

    assign flush_ready_o = (r_state == c_IDLE);
    assign req_valid_o   = (r_state == c_REQ);
    assign res_ready_o   = (r_state == c_RESP);
    assign evict_valid_o = (r_state == c_EVICT);
    assign busy_o        = (r_state != c_IDLE);
    assign done_o        = (r_state == c_DONE);
    assign req_o         = w_req;
    assign evict_tag_o   = r_evict_tag;
    assign evict_index_o = r_evict_index;
    assign evict_way_o   = r_evict_way;
    assign flushed_o     = r_flushed;

endmodule
`default_nettype wire
